// File: rtl/perf_dump.sv
// perf_dump: snapshots the perf counters on request and streams them
// as an ASCII hex frame over a valid/ready byte handshake.
module perf_dump #(
  parameter bit UPPER_HEX = 1'b1,
  parameter bit CRLF      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cycle_cnt,
  input  logic [15:0] instr_cnt,
  input  logic        dump_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        dump_done,
  output logic        overrun,
  input  logic        clr_ovr
);

  localparam logic [3:0] LAST = CRLF ? 4'd11 : 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SEND
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] snap_cyc;
  logic [15:0] snap_ins;
  logic [3:0]  idx;
  logic        xfer;
  logic        last_xfer;

  function automatic logic [7:0] hex(input logic [3:0] n);
    logic [7:0] base;
    if (n < 4'd10) base = 8'h30;
    else base = UPPER_HEX ? 8'h37 : 8'h57;
    return base + {4'h0, n};
  endfunction

  assign xfer      = tx_valid & tx_ready;
  assign last_xfer = xfer && (idx == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (dump_req) state_nxt = ARM;
      ARM:  state_nxt = SEND;
      SEND: if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ARM exists so the counters settle for one cycle after a stop strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_cyc  <= '0;
      snap_ins  <= '0;
      idx       <= '0;
      dump_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state == ARM) begin
        snap_cyc <= cycle_cnt;
        snap_ins <= instr_cnt;
        idx      <= '0;
      end else if (xfer) begin
        idx <= idx + 4'd1;
      end
      dump_done <= last_xfer;
      if (dump_req && state != IDLE) overrun <= 1'b1;
      else if (clr_ovr)              overrun <= 1'b0;
    end
  end

  always_comb begin
    tx_valid = (state == SEND);
    busy     = (state != IDLE);
    tx_data  = 8'h00;
    if (state == SEND) begin
      case (idx)
        4'd0:    tx_data = 8'h43;
        4'd1:    tx_data = hex(snap_cyc[15:12]);
        4'd2:    tx_data = hex(snap_cyc[11:8]);
        4'd3:    tx_data = hex(snap_cyc[7:4]);
        4'd4:    tx_data = hex(snap_cyc[3:0]);
        4'd5:    tx_data = 8'h49;
        4'd6:    tx_data = hex(snap_ins[15:12]);
        4'd7:    tx_data = hex(snap_ins[11:8]);
        4'd8:    tx_data = hex(snap_ins[7:4]);
        4'd9:    tx_data = hex(snap_ins[3:0]);
        4'd10:   tx_data = 8'h0D;
        4'd11:   tx_data = 8'h0A;
        default: tx_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_dump.sv
// tb_perf_dump: two perf_dump instances (upper/CRLF and lower/no-term)
// driven in lockstep and checked against a string-formatting model.
module tb_perf_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cycle_cnt;
  logic [15:0] instr_cnt;
  logic        dump_req;
  logic        tx_ready;
  logic        clr_ovr;

  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1;
  logic       busy0, busy1;
  logic       dump_done0, dump_done1;
  logic       overrun0, overrun1;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int mode   = 0;
  bit inc    = 1'b0;

  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int  done0, done1;
  int  t_first0, t_last0, t_done0, req_at;
  bit  stall0, stall1;
  logic [7:0] held0, held1;

  always #5 clk = ~clk;

  perf_dump #(.UPPER_HEX(1'b1), .CRLF(1'b1)) u0 (
    .clk(clk), .rst(rst), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
    .dump_req(dump_req), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready), .busy(busy0), .dump_done(dump_done0),
    .overrun(overrun0), .clr_ovr(clr_ovr)
  );

  perf_dump #(.UPPER_HEX(1'b0), .CRLF(1'b0)) u1 (
    .clk(clk), .rst(rst), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
    .dump_req(dump_req), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .busy(busy1), .dump_done(dump_done1),
    .overrun(overrun1), .clr_ovr(clr_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: printf-style hex text, case forced per variant
  function automatic void mk(input logic [15:0] c, input logic [15:0] i,
                             input bit up, input bit cr,
                             output logic [7:0] q[$]);
    string s;
    logic [7:0] b;
    s = $sformatf("C%04hI%04h", c, i);
    q = {};
    for (int k = 0; k < s.len(); k++) begin
      b = s[k];
      if (k != 0 && k != 5) begin
        if (b >= 8'h41 && b <= 8'h46) b = b + 8'h20;
        if (up && b >= 8'h61 && b <= 8'h66) b = b - 8'h20;
      end
      q.push_back(b);
    end
    if (cr) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
  endfunction

  task automatic step();
    if (mode == 1) tx_ready = 1'($urandom_range(0, 1));
    if (mode == 2) tx_ready = (cyc_n % 3 == 0);
    if (stall0) chk("hold0", tx_data0, held0);
    if (stall1) chk("hold1", tx_data1, held1);
    if (tx_valid0 && tx_ready) begin
      if (got0.size() == 0) t_first0 = cyc_n;
      t_last0 = cyc_n;
      got0.push_back(tx_data0);
    end
    if (tx_valid1 && tx_ready) got1.push_back(tx_data1);
    stall0 = tx_valid0 && !tx_ready;
    stall1 = tx_valid1 && !tx_ready;
    held0  = tx_data0;
    held1  = tx_data1;
    if (dump_done0) begin
      done0++;
      t_done0 = cyc_n;
    end
    if (dump_done1) done1++;
    @(posedge clk);
    #1;
    cyc_n++;
    if (inc) begin
      cycle_cnt = cycle_cnt + 16'd1;
      instr_cnt = instr_cnt + 16'd3;
    end
  endtask

  task automatic request();
    req_at   = cyc_n;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int k;
    k = 0;
    while ((busy0 || busy1) && k < budget) begin
      step();
      k++;
    end
    step();
    chk("frame_timeout", {busy0, busy1}, 2'b00);
  endtask

  task automatic clear_mon();
    got0 = {};
    got1 = {};
    done0 = 0;
    done1 = 0;
    stall0 = 1'b0;
    stall1 = 1'b0;
  endtask

  task automatic check_frame(input logic [15:0] c, input logic [15:0] i);
    logic [7:0] e0[$];
    logic [7:0] e1[$];
    mk(c, i, 1'b1, 1'b1, e0);
    mk(c, i, 1'b0, 1'b0, e1);
    chk("len0", got0.size(), e0.size());
    chk("len1", got1.size(), e1.size());
    for (int k = 0; k < e0.size() && k < got0.size(); k++)
      chk($sformatf("u0_byte%0d", k), got0[k], e0[k]);
    for (int k = 0; k < e1.size() && k < got1.size(); k++)
      chk($sformatf("u1_byte%0d", k), got1[k], e1[k]);
    chk("done_cnt0", done0, 1);
    chk("done_cnt1", done1, 1);
    clear_mon();
  endtask

  initial begin
    logic [7:0] lit[12];
    logic [15:0] rc, ri;
    int k;
    lit = '{8'h43, 8'h31, 8'h32, 8'h41, 8'h42, 8'h49,
            8'h30, 8'h30, 8'h46, 8'h30, 8'h0D, 8'h0A};
    rst = 1'b0;
    cycle_cnt = '0;
    instr_cnt = '0;
    dump_req = 1'b0;
    tx_ready = 1'b0;
    clr_ovr = 1'b0;
    clear_mon();
    #12;
    chk("rst_valid", {tx_valid0, tx_valid1}, 2'b00);
    chk("rst_data", {tx_data0, tx_data1}, 16'h0000);
    chk("rst_busy", {busy0, busy1}, 2'b00);
    chk("rst_done", {dump_done0, dump_done1}, 2'b00);
    chk("rst_ovr", {overrun0, overrun1}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    step();

    // basic frame with latency and spacing
    cycle_cnt = 16'h12AB;
    instr_cnt = 16'h00F0;
    tx_ready = 1'b1;
    request();
    wait_frame(40);
    for (int j = 0; j < 12 && j < got0.size(); j++)
      chk($sformatf("basic_lit%0d", j), got0[j], lit[j]);
    chk("first_lat", t_first0, req_at + 2);
    chk("span", t_last0, t_first0 + 11);
    chk("done_time", t_done0, t_last0 + 1);
    chk("busy_after", busy0, 1'b0);
    check_frame(16'h12AB, 16'h00F0);

    // snapshot one cycle after request while counters run
    cycle_cnt = 16'h0010;
    instr_cnt = 16'h0500;
    inc = 1'b1;
    request();
    wait_frame(40);
    inc = 1'b0;
    check_frame(16'h0011, 16'h0503);

    // backpressure 1,0,0 pattern
    cycle_cnt = 16'hBEEF;
    instr_cnt = 16'hCAFE;
    mode = 2;
    request();
    wait_frame(80);
    mode = 0;
    tx_ready = 1'b1;
    check_frame(16'hBEEF, 16'hCAFE);

    // overrun set, sticky, cleared, and set-wins on conflict
    cycle_cnt = 16'h9A3C;
    instr_cnt = 16'h7E01;
    request();
    k = 0;
    while (got0.size() < 3 && k < 20) begin
      step();
      k++;
    end
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    step();
    chk("ovr_set", {overrun0, overrun1}, 2'b11);
    wait_frame(40);
    check_frame(16'h9A3C, 16'h7E01);
    chk("ovr_sticky", {overrun0, overrun1}, 2'b11);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr", {overrun0, overrun1}, 2'b00);
    request();
    step();
    step();
    dump_req = 1'b1;
    clr_ovr = 1'b1;
    step();
    dump_req = 1'b0;
    clr_ovr = 1'b0;
    chk("ovr_setwins", {overrun0, overrun1}, 2'b11);
    wait_frame(40);
    check_frame(16'h9A3C, 16'h7E01);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;

    // asynchronous reset mid-frame, then a fresh frame
    cycle_cnt = 16'h4D2E;
    instr_cnt = 16'hA0B1;
    request();
    k = 0;
    while (got0.size() < 5 && k < 20) begin
      step();
      k++;
    end
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {tx_valid0, tx_valid1}, 2'b00);
    chk("arst_busy", {busy0, busy1}, 2'b00);
    chk("arst_data", {tx_data0, tx_data1}, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_mon();
    cycle_cnt = 16'h0F5D;
    instr_cnt = 16'hE6C7;
    request();
    wait_frame(40);
    check_frame(16'h0F5D, 16'hE6C7);

    // back-to-back request in the dump_done cycle
    cycle_cnt = 16'h1111;
    instr_cnt = 16'h2222;
    request();
    k = 0;
    while (!dump_done0 && k < 40) begin
      step();
      k++;
    end
    chk("b2b_done_seen", dump_done0, 1'b1);
    cycle_cnt = 16'hFEDC;
    instr_cnt = 16'hBA98;
    request();
    check_frame(16'h1111, 16'h2222);
    wait_frame(40);
    check_frame(16'hFEDC, 16'hBA98);
    chk("b2b_ovr", {overrun0, overrun1}, 2'b00);

    // randomized counters and random tx_ready
    mode = 1;
    repeat (8) begin
      rc = 16'($urandom);
      ri = 16'($urandom);
      cycle_cnt = rc;
      instr_cnt = ri;
      request();
      wait_frame(200);
      check_frame(rc, ri);
      repeat ($urandom_range(0, 3)) step();
    end
    chk("final_ovr", {overrun0, overrun1}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
